// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, pending-request payload, owner ids.
package def_arb;

  localparam int unsigned ARB_ADDR_W = 64;
  localparam int unsigned ARB_DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FENCE = 3'd4
  } arb_state_t;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [1:0]            size;
    logic                  write;
    logic [ARB_DATA_W-1:0] wdata;
    logic                  fence_i;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and downstream memory handshakes seen by the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              i_en;
  logic [ADDR_W-1:0] i_addr;
  logic [1:0]        i_size;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_acc_err;
  logic              i_ready;

  logic              d_en;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_size;
  logic              d_write;
  logic [DATA_W-1:0] d_wdata;
  logic              d_fence_i;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_acc_err;
  logic              d_ready;

  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_size;
  logic              m_write;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;

  // Arbiter view.
  modport slave (
    input  i_en, i_addr, i_size, i_ready,
    input  d_en, d_addr, d_size, d_write, d_wdata, d_fence_i, d_ready,
    input  m_gnt, m_rvalid, m_rdata, m_err,
    output i_valid, i_rdata, i_acc_err,
    output d_valid, d_rdata, d_acc_err,
    output m_req, m_addr, m_size, m_write, m_wdata
  );

  // Pipeline stages plus downstream port view.
  modport master (
    output i_en, i_addr, i_size, i_ready,
    output d_en, d_addr, d_size, d_write, d_wdata, d_fence_i, d_ready,
    output m_gnt, m_rvalid, m_rdata, m_err,
    input  i_valid, i_rdata, i_acc_err,
    input  d_valid, d_rdata, d_acc_err,
    input  m_req, m_addr, m_size, m_write, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_req_slot.sv
// One pending-request register with a valid flag; clear wins over load.
module arb_req_slot
  import def_arb::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     load,
  input  logic     clear,
  input  mem_req_t req_in,
  output logic     valid,
  output mem_req_t req
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      req   <= req_in;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between fetch and data; one transaction at a time,
// response held until the owning stage takes it.
module mem_port_arbiter
  import def_arb::*;
#(
  parameter int unsigned ADDR_W     = ARB_ADDR_W,
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic [CNT_W-1:0] starve_q;

  logic     i_pend, d_pend, i_load, d_load, i_clear, d_clear;
  logic     grant_i, grant_d, i_busy, d_busy;
  mem_req_t i_req_in, d_req_in, i_req, d_req, win;

  assign i_req_in = '{addr: ARB_ADDR_W'(bus.i_addr), size: bus.i_size, write: 1'b0,
                      wdata: '0, fence_i: 1'b0};
  assign d_req_in = '{addr: ARB_ADDR_W'(bus.d_addr), size: bus.d_size, write: bus.d_write,
                      wdata: ARB_DATA_W'(bus.d_wdata), fence_i: bus.d_fence_i};

  // A side is busy from grant until the cycle its response is released.
  assign i_busy = (owner_q == ARB_OWNER_I) &&
                  ((state_q == WAIT) || ((state_q == HOLD) && !bus.i_ready));
  assign d_busy = (owner_q == ARB_OWNER_D) &&
                  ((state_q == WAIT) || (((state_q == HOLD) || (state_q == FENCE)) && !bus.d_ready));

  assign i_load = bus.i_en && !i_pend && !i_busy;
  assign d_load = bus.d_en && !d_pend && !d_busy;

  arb_req_slot u_i_slot (
    .clock (clock), .reset (reset), .load (i_load), .clear (i_clear),
    .req_in (i_req_in), .valid (i_pend), .req (i_req)
  );

  arb_req_slot u_d_slot (
    .clock (clock), .reset (reset), .load (d_load), .clear (d_clear),
    .req_in (d_req_in), .valid (d_pend), .req (d_req)
  );

  assign win = grant_d ? d_req : i_req;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= ARB_OWNER_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Arbitration and next state; data wins unless fetch has waited STARVE_MAX grants.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    i_clear = 1'b0;
    d_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_pend && (!i_pend || (starve_q != CNT_W'(STARVE_MAX)))) begin
          grant_d = 1'b1;
          owner_d = ARB_OWNER_D;
          state_d = d_req.fence_i ? FENCE : REQ;
          d_clear = d_req.fence_i;
        end else if (i_pend) begin
          grant_i = 1'b1;
          owner_d = ARB_OWNER_I;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.m_gnt) begin
          state_d = WAIT;
          i_clear = (owner_q == ARB_OWNER_I);
          d_clear = (owner_q == ARB_OWNER_D);
        end
      end
      WAIT:  if (bus.m_rvalid) state_d = HOLD;
      HOLD:  if ((owner_q == ARB_OWNER_D) ? bus.d_ready : bus.i_ready) state_d = IDLE;
      FENCE: if (bus.d_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else if (grant_i || !i_pend) begin
      starve_q <= '0;
    end else if (grant_d && (starve_q != CNT_W'(STARVE_MAX))) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

  // Registered downstream payload and per-side responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.m_req     <= 1'b0;
      bus.m_addr    <= '0;
      bus.m_size    <= '0;
      bus.m_write   <= 1'b0;
      bus.m_wdata   <= '0;
      bus.i_valid   <= 1'b0;
      bus.i_rdata   <= '0;
      bus.i_acc_err <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_acc_err <= 1'b0;
    end else begin
      bus.m_req   <= (state_d == REQ);
      bus.i_valid <= (state_d == HOLD) && (owner_d == ARB_OWNER_I);
      bus.d_valid <= ((state_d == HOLD) && (owner_d == ARB_OWNER_D)) || (state_d == FENCE);
      if ((grant_i || grant_d) && (state_d == REQ)) begin
        bus.m_addr  <= ADDR_W'(win.addr);
        bus.m_size  <= win.size;
        bus.m_write <= win.write;
        bus.m_wdata <= DATA_W'(win.wdata);
      end
      if ((state_q == WAIT) && bus.m_rvalid) begin
        if (owner_q == ARB_OWNER_D) begin
          bus.d_rdata   <= bus.m_rdata;
          bus.d_acc_err <= bus.m_err;
        end else begin
          bus.i_rdata   <= bus.m_rdata;
          bus.i_acc_err <= bus.m_err;
        end
      end
      if (state_d == FENCE && state_q == IDLE) begin
        bus.d_rdata   <= '0;
        bus.d_acc_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written multi-cycle sequences (arbitration order, starvation, backpressure, reset).
module tb_mem_port_arbiter;
  import def_arb::*;

  logic clock;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          side_d;
    logic [63:0] addr;
    logic [1:0]  size;
    bit          write;
    logic [63:0] wdata;
    bit          fence;
    int          gnt_wait;
    logic [63:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_mreq;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        write;
    logic [63:0] wdata;
  } dn_t;

  int  n_vec  = 0;
  int  n_miss = 0;
  dn_t log_q[$];
  bit  auto_rvalid = 1'b1;
  bit  man_rvalid  = 1'b0;
  bit  rsp_pending = 1'b0;
  logic [63:0] rsp_addr = '0;
  int  gnt_wait = 0;
  int  req_age  = 0;
  int  i_seen   = 0;
  int  d_seen   = 0;

  function automatic logic [63:0] rdata_fn(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_1000) return 64'h1122_3344_5566_7788;
    return {~a[31:0], a[31:0]};
  endfunction

  function automatic logic err_fn(input logic [63:0] a);
    return a[63:60] == 4'hF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: downstream model acts on the current outputs, then pulses are dropped.
  task automatic tick();
    bus.m_gnt    = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_err    = 1'b0;
    bus.m_rdata  = '0;
    if (reset) begin
      rsp_pending = 1'b0;
      req_age     = 0;
    end else if (rsp_pending) begin
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = rdata_fn(rsp_addr);
      bus.m_err    = err_fn(rsp_addr);
      rsp_pending  = 1'b0;
    end else if (man_rvalid) begin
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
      bus.m_err    = 1'b1;
      man_rvalid   = 1'b0;
    end
    if (bus.m_req && !reset) begin
      if (req_age >= gnt_wait) begin
        bus.m_gnt = 1'b1;
        req_age   = 0;
        log_q.push_back('{addr: bus.m_addr, size: bus.m_size, write: bus.m_write, wdata: bus.m_wdata});
        if (auto_rvalid) begin
          rsp_pending = 1'b1;
          rsp_addr    = bus.m_addr;
        end
      end else begin
        req_age++;
      end
    end
    @(posedge clock);
    @(negedge clock);
    bus.i_en = 1'b0;
    bus.d_en = 1'b0;
    if (bus.i_valid) i_seen++;
    if (bus.d_valid) d_seen++;
  endtask

  task automatic wait_valid(input bit side_d, input int max, output int lat,
                            output logic [63:0] rd, output logic er);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (side_d ? bus.d_valid : bus.i_valid) begin
        lat = k;
        rd  = side_d ? bus.d_rdata : bus.i_rdata;
        er  = side_d ? bus.d_acc_err : bus.i_acc_err;
        break;
      end
    end
    if (lat < 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout waiting for %s_valid", side_d ? "d" : "i");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    int          lat, sent, d_cyc, i_cyc;
    logic [63:0] rd, rd_i, rd_d;
    logic        er;
    logic [63:0] exp_addr[6];

    vecs[0] = '{1, 64'h0000_0000_8000_1000, 2'd3, 0, 64'h0, 0, 0, 64'h1122_3344_5566_7788, 0, 4, 1};
    vecs[1] = '{0, 64'h0000_0000_8000_0000, 2'd2, 0, 64'h0, 0, 0, 64'h7FFF_FFFF_8000_0000, 0, 4, 1};
    vecs[2] = '{1, 64'hF000_0000_0000_0010, 2'd3, 1, 64'h0000_0000_0000_DEAD, 0, 0, 64'hFFFF_FFEF_0000_0010, 1, 4, 1};
    vecs[3] = '{1, 64'h0000_0000_0000_0000, 2'd0, 0, 64'h0, 1, 0, 64'h0, 0, 2, 0};
    vecs[4] = '{0, 64'hF000_0000_0000_0008, 2'd2, 0, 64'h0, 0, 0, 64'hFFFF_FFF7_0000_0008, 1, 4, 1};
    vecs[5] = '{1, 64'h0000_0004_0000_0040, 2'd1, 0, 64'h0, 0, 2, 64'hFFFF_FFBF_0000_0040, 0, 6, 1};
    exp_addr = '{64'h4000, 64'h4008, 64'h4010, 64'h4018, 64'h3000, 64'h4020};

    reset = 1'b1;
    bus.i_en = 0; bus.i_addr = '0; bus.i_size = '0; bus.i_ready = 1'b1;
    bus.d_en = 0; bus.d_addr = '0; bus.d_size = '0; bus.d_write = 0; bus.d_wdata = '0;
    bus.d_fence_i = 0; bus.d_ready = 1'b1;
    bus.m_gnt = 0; bus.m_rvalid = 0; bus.m_rdata = '0; bus.m_err = 0;
    @(negedge clock);
    repeat (3) tick();
    reset = 1'b0;

    check("reset_ctrl", 64'({bus.m_req, bus.i_valid, bus.d_valid, bus.i_acc_err, bus.d_acc_err,
                              bus.m_write, bus.m_size}), 64'h0);
    check("reset_m_addr", bus.m_addr, 64'h0);
    check("reset_rdata", bus.i_rdata | bus.d_rdata | bus.m_wdata, 64'h0);

    // Single transactions from idle.
    for (int v = 0; v < 6; v++) begin
      log_q.delete();
      i_seen = 0; d_seen = 0;
      gnt_wait = vecs[v].gnt_wait;
      if (vecs[v].side_d) begin
        bus.d_addr = vecs[v].addr; bus.d_size = vecs[v].size; bus.d_write = vecs[v].write;
        bus.d_wdata = vecs[v].wdata; bus.d_fence_i = vecs[v].fence; bus.d_en = 1'b1;
      end else begin
        bus.i_addr = vecs[v].addr; bus.i_size = vecs[v].size; bus.i_en = 1'b1;
      end
      wait_valid(vecs[v].side_d, 30, lat, rd, er);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("v%0d_acc_err", v), 64'(er), 64'(vecs[v].exp_err));
      repeat (3) tick();
      check($sformatf("v%0d_other_valid", v), 64'(vecs[v].side_d ? i_seen : d_seen), 64'h0);
      check($sformatf("v%0d_m_req_count", v), 64'(log_q.size()), 64'(vecs[v].exp_mreq));
      if (vecs[v].exp_mreq == 1 && log_q.size() == 1) begin
        check($sformatf("v%0d_m_payload", v),
              log_q[0].addr ^ log_q[0].wdata ^ 64'({log_q[0].size, log_q[0].write}),
              vecs[v].addr ^ vecs[v].wdata ^ 64'({vecs[v].size, vecs[v].write}));
      end
      bus.d_fence_i = 1'b0;
      bus.d_write   = 1'b0;
    end
    gnt_wait = 0;

    // Simultaneous fetch and data: data goes downstream first.
    log_q.delete();
    d_cyc = -1; i_cyc = -1; rd_i = '0; rd_d = '0;
    bus.i_addr = 64'h1000; bus.i_en = 1'b1;
    bus.d_addr = 64'h2000; bus.d_en = 1'b1;
    for (int k = 0; k < 40 && (d_cyc < 0 || i_cyc < 0); k++) begin
      tick();
      if (bus.d_valid && d_cyc < 0) begin d_cyc = k; rd_d = bus.d_rdata; end
      if (bus.i_valid && i_cyc < 0) begin i_cyc = k; rd_i = bus.i_rdata; end
    end
    check("simul_grants", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      check("simul_first_addr", log_q[0].addr, 64'h2000);
      check("simul_second_addr", log_q[1].addr, 64'h1000);
    end
    check("simul_d_rdata", rd_d, rdata_fn(64'h2000));
    check("simul_i_rdata", rd_i, rdata_fn(64'h1000));
    check("simul_d_before_i", 64'(d_cyc >= 0 && i_cyc > d_cyc), 64'd1);

    // Starvation: fetch waits behind back-to-back data requests.
    repeat (2) tick();
    log_q.delete();
    bus.i_addr = 64'h3000; bus.i_en = 1'b1;
    bus.d_addr = 64'h4000; bus.d_en = 1'b1;
    sent = 1;
    for (int k = 0; k < 200 && log_q.size() < 6; k++) begin
      tick();
      if (bus.d_valid && sent < 5) begin
        bus.d_addr = 64'h4000 + 64'(sent * 8);
        bus.d_en   = 1'b1;
        sent++;
      end
    end
    repeat (6) tick();
    check("starve_grants", 64'(log_q.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < log_q.size()) check($sformatf("starve_grant%0d", k), log_q[k].addr, exp_addr[k]);
    end

    // Backpressure: response held, no new request while data stage stalls.
    log_q.delete();
    bus.d_ready = 1'b0;
    bus.d_addr = 64'h5000; bus.d_en = 1'b1;
    wait_valid(1'b1, 20, lat, rd, er);
    check("bp_first_rdata", rd, rdata_fn(64'h5000));
    bus.i_addr = 64'h6000; bus.i_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("bp_d_valid_%0d", k), 64'(bus.d_valid), 64'd1);
      check($sformatf("bp_d_rdata_%0d", k), bus.d_rdata, rdata_fn(64'h5000));
      check($sformatf("bp_m_req_%0d", k), 64'(bus.m_req), 64'd0);
    end
    check("bp_grants_held", 64'(log_q.size()), 64'd1);
    bus.d_ready = 1'b1;
    wait_valid(1'b0, 20, lat, rd, er);
    check("bp_i_rdata", rd, rdata_fn(64'h6000));
    check("bp_i_latency", 64'(lat), 64'd4);
    if (log_q.size() >= 2) check("bp_second_addr", log_q[1].addr, 64'h6000);
    else check("bp_second_grant", 64'(log_q.size()), 64'd2);

    // Reset while waiting on downstream; late response must be dropped.
    repeat (2) tick();
    auto_rvalid = 1'b0;
    bus.d_addr = 64'h7000; bus.d_en = 1'b1;
    repeat (4) tick();
    check("rst_state_wait", 64'(dut.state_q), 64'(WAIT));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_ctrl", 64'({bus.m_req, bus.i_valid, bus.d_valid, bus.i_acc_err, bus.d_acc_err,
                            bus.m_write, bus.m_size}), 64'h0);
    check("rst_data", bus.m_addr | bus.m_wdata | bus.i_rdata | bus.d_rdata, 64'h0);
    i_seen = 0; d_seen = 0;
    man_rvalid = 1'b1;
    repeat (5) tick();
    check("rst_no_valid", 64'(i_seen + d_seen), 64'd0);
    check("rst_state_idle", 64'(dut.state_q), 64'(IDLE));
    check("rst_no_req", 64'(bus.m_req), 64'd0);
    auto_rvalid = 1'b1;
    bus.d_addr = 64'h8000; bus.d_en = 1'b1;
    wait_valid(1'b1, 20, lat, rd, er);
    check("rst_recover_rdata", rd, rdata_fn(64'h8000));
    check("rst_recover_latency", 64'(lat), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
